// File: rtl/dpll_decision_engine.sv
// rtl/dpll_decision_engine.sv - DPLL decision/backtrack sequencer driving an external BCP unit.
// Optional phase saving is enabled by defining DPLL_DECISION_ENGINE_PHASE_SAVE_EN.
module dpll_decision_engine #(
   parameter int NUM_VARS = 20,
   parameter int VW       = $clog2(NUM_VARS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                conflict,
   input  logic                bcp_done,
   output logic                dec_valid,
   output logic [VW-1:0]       dec_var,
   output logic                dec_value,
   output logic [VW-1:0]       level,
   output logic [NUM_VARS-1:0] assign_mask,
   output logic [NUM_VARS-1:0] value_vec,
   output logic                busy,
   output logic                dp_sat,
   output logic                dp_unsat
);

   typedef enum logic [2:0] {
      IDLE,
      DECIDE,
      WAIT_BCP,
      BACKTRACK,
      SAT,
      UNSAT
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [VW-1:0]       level_nxt;
   logic [VW-1:0]       dec_var_nxt;
   logic                dec_valid_nxt;
   logic                dec_value_nxt;
   logic [NUM_VARS-1:0] mask_nxt;
   logic [NUM_VARS-1:0] vec_nxt;
   logic [NUM_VARS-1:0] flipped;
   logic [NUM_VARS-1:0] flipped_nxt;
   logic [NUM_VARS-1:0] cur_bit;
   logic [NUM_VARS-1:0] new_bit;
   logic                cur_val;
   logic                cur_flipped;
   logic                polarity;
   logic                pop;

   // cur_bit selects the variable at the current level, new_bit the next one to decide.
   always_comb begin
      cur_bit = '0;
      new_bit = '0;
      for (int i = 0; i < NUM_VARS; i++) begin
         cur_bit[i] = (int'(level) == i + 1);
         new_bit[i] = (int'(level) == i);
      end
   end

   assign cur_val     = |(value_vec & cur_bit);
   assign cur_flipped = |(flipped & cur_bit);
   assign pop         = (state == BACKTRACK) && (level != '0) && cur_flipped;

`ifdef DPLL_DECISION_ENGINE_PHASE_SAVE_EN
   logic [NUM_VARS-1:0] saved_phase;
   logic [NUM_VARS-1:0] saved_phase_nxt;

   always_comb begin
      saved_phase_nxt = saved_phase;
      if (start && (state == IDLE || state == SAT || state == UNSAT)) begin
         saved_phase_nxt = '0;
      end else if (pop) begin
         saved_phase_nxt = (saved_phase & ~cur_bit) | (value_vec & cur_bit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         saved_phase <= '0;
      end else begin
         saved_phase <= saved_phase_nxt;
      end
   end

   assign polarity = |(saved_phase & new_bit);
`else
   assign polarity = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      level_nxt     = level;
      mask_nxt      = assign_mask;
      vec_nxt       = value_vec;
      flipped_nxt   = flipped;
      dec_valid_nxt = 1'b0;
      dec_var_nxt   = dec_var;
      dec_value_nxt = dec_value;
      case (state)
         IDLE, SAT, UNSAT: begin
            if (start) begin
               level_nxt   = '0;
               mask_nxt    = '0;
               vec_nxt     = '0;
               flipped_nxt = '0;
               state_nxt   = DECIDE;
            end
         end
         DECIDE: begin
            level_nxt     = level + VW'(1);
            mask_nxt      = assign_mask | new_bit;
            vec_nxt       = polarity ? (value_vec | new_bit) : (value_vec & ~new_bit);
            flipped_nxt   = flipped & ~new_bit;
            dec_valid_nxt = 1'b1;
            dec_var_nxt   = level + VW'(1);
            dec_value_nxt = polarity;
            state_nxt     = WAIT_BCP;
         end
         WAIT_BCP: begin
            if (conflict) begin
               state_nxt = BACKTRACK;
            end else if (bcp_done) begin
               state_nxt = (int'(level) == NUM_VARS) ? SAT : DECIDE;
            end
         end
         BACKTRACK: begin
            if (level == '0) begin
               state_nxt = UNSAT;
            end else if (!cur_flipped) begin
               vec_nxt       = value_vec ^ cur_bit;
               flipped_nxt   = flipped | cur_bit;
               dec_valid_nxt = 1'b1;
               dec_var_nxt   = level;
               dec_value_nxt = ~cur_val;
               state_nxt     = WAIT_BCP;
            end else begin
               // Both polarities exhausted at this level: pop it and keep backtracking.
               mask_nxt    = assign_mask & ~cur_bit;
               vec_nxt     = value_vec & ~cur_bit;
               flipped_nxt = flipped & ~cur_bit;
               level_nxt   = level - VW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         level       <= '0;
         assign_mask <= '0;
         value_vec   <= '0;
         flipped     <= '0;
         dec_valid   <= 1'b0;
         dec_var     <= '0;
         dec_value   <= 1'b0;
      end else begin
         state       <= state_nxt;
         level       <= level_nxt;
         assign_mask <= mask_nxt;
         value_vec   <= vec_nxt;
         flipped     <= flipped_nxt;
         dec_valid   <= dec_valid_nxt;
         dec_var     <= dec_var_nxt;
         dec_value   <= dec_value_nxt;
      end
   end

   assign busy     = (state == DECIDE) || (state == WAIT_BCP) || (state == BACKTRACK);
   assign dp_sat   = (state == SAT);
   assign dp_unsat = (state == UNSAT);

endmodule

// File: tb/tb_dpll_decision_engine.sv
// tb/tb_dpll_decision_engine.sv - directed vector bench for dpll_decision_engine (3-var and 1-var instances).
module tb_dpll_decision_engine;

`ifdef DPLL_DECISION_ENGINE_PHASE_SAVE_EN
   localparam logic PS = 1'b1;
`else
   localparam logic PS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst3, start3, conflict3, bcp_done3;
   logic       dec_valid3, dec_value3, busy3, sat3, unsat3;
   logic [1:0] dec_var3, level3;
   logic [2:0] mask3, vec3;

   logic rst1, start1, conflict1, bcp_done1;
   logic dec_valid1, dec_value1, busy1, sat1, unsat1;
   logic [0:0] dec_var1, level1, mask1, vec1;

   dpll_decision_engine #(.NUM_VARS(3)) u3 (
      .clk(clk), .rst(rst3), .start(start3), .conflict(conflict3), .bcp_done(bcp_done3),
      .dec_valid(dec_valid3), .dec_var(dec_var3), .dec_value(dec_value3), .level(level3),
      .assign_mask(mask3), .value_vec(vec3), .busy(busy3), .dp_sat(sat3), .dp_unsat(unsat3)
   );

   dpll_decision_engine #(.NUM_VARS(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .conflict(conflict1), .bcp_done(bcp_done1),
      .dec_valid(dec_valid1), .dec_var(dec_var1), .dec_value(dec_value1), .level(level1),
      .assign_mask(mask1), .value_vec(vec1), .busy(busy1), .dp_sat(sat1), .dp_unsat(unsat1)
   );

   // exp packs {dec_valid, dec_var, dec_value, level, assign_mask, value_vec, busy, dp_sat, dp_unsat}
   typedef struct {
      logic        rst;
      logic        start;
      logic        conflict;
      logic        bcp_done;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic r, input logic s, input logic c, input logic d,
                      input logic dv, input logic [1:0] vr, input logic vl, input logic [1:0] lv,
                      input logic [2:0] m, input logic [2:0] v, input logic b, input logic st,
                      input logic un);
      vec_t e;
      e.rst = r; e.start = s; e.conflict = c; e.bcp_done = d;
      e.exp = {dv, vr, vl, lv, m, v, b, st, un};
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int cnt;
      bit found;
      rst3 = 1'b0; start3 = 1'b0; conflict3 = 1'b0; bcp_done3 = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; conflict1 = 1'b0; bcp_done1 = 1'b0;

      //   r s c d   dv var val lvl  mask    vec          b st un
      add(1,0,0,0, 0,2'd0,0 ,2'd0,3'b000,3'b000,      0,0,0); // 0 reset
      add(0,0,0,0, 0,2'd0,0 ,2'd0,3'b000,3'b000,      0,0,0); // 1 idle
      add(0,1,0,0, 0,2'd0,0 ,2'd0,3'b000,3'b000,      1,0,0); // 2 DECIDE
      add(0,0,0,0, 1,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0); // 3 (1,0)
      add(0,0,0,1, 0,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd2,0 ,2'd2,3'b011,3'b000,      1,0,0); // (2,0)
      add(0,0,0,1, 0,2'd2,0 ,2'd2,3'b011,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd3,0 ,2'd3,3'b111,3'b000,      1,0,0); // (3,0)
      add(0,0,0,1, 0,2'd3,0 ,2'd3,3'b111,3'b000,      0,1,0); // SAT
      add(0,0,1,1, 0,2'd3,0 ,2'd3,3'b111,3'b000,      0,1,0); // 9 ignored in SAT
      add(0,1,0,0, 0,2'd3,0 ,2'd0,3'b000,3'b000,      1,0,0); // 10 restart
      add(0,0,0,0, 1,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0);
      add(0,0,0,1, 0,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd2,0 ,2'd2,3'b011,3'b000,      1,0,0);
      add(0,0,0,1, 0,2'd2,0 ,2'd2,3'b011,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd3,0 ,2'd3,3'b111,3'b000,      1,0,0); // 15 (3,0)
      add(0,0,1,0, 0,2'd3,0 ,2'd3,3'b111,3'b000,      1,0,0); // BACKTRACK
      add(0,0,0,0, 1,2'd3,1 ,2'd3,3'b111,3'b100,      1,0,0); // flip (3,1)
      add(0,0,1,0, 0,2'd3,1 ,2'd3,3'b111,3'b100,      1,0,0);
      add(0,0,0,0, 0,2'd3,1 ,2'd2,3'b011,3'b000,      1,0,0); // 19 pop 3->2
      add(0,0,0,0, 1,2'd2,1 ,2'd2,3'b011,3'b010,      1,0,0); // flip (2,1)
      add(0,0,0,1, 0,2'd2,1 ,2'd2,3'b011,3'b010,      1,0,0);
      add(0,0,0,0, 1,2'd3,PS,2'd3,3'b111,{PS,2'b10},  1,0,0); // 22 redecide var3
      add(0,0,0,1, 0,2'd3,PS,2'd3,3'b111,{PS,2'b10},  0,1,0); // SAT
      add(0,1,0,0, 0,2'd3,PS,2'd0,3'b000,3'b000,      1,0,0); // 24 restart
      add(0,0,0,0, 1,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0);
      add(0,0,0,1, 0,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd2,0 ,2'd2,3'b011,3'b000,      1,0,0);
      add(0,0,1,1, 0,2'd2,0 ,2'd2,3'b011,3'b000,      1,0,0); // 28 conflict wins
      add(0,0,0,0, 1,2'd2,1 ,2'd2,3'b011,3'b010,      1,0,0); // (2,1)
      add(1,1,0,1, 0,2'd0,0 ,2'd0,3'b000,3'b000,      0,0,0); // 30 rst mid-solve
      add(0,0,0,0, 0,2'd0,0 ,2'd0,3'b000,3'b000,      0,0,0); // no pulse after rst
      add(0,1,0,0, 0,2'd0,0 ,2'd0,3'b000,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0); // (1,0)
      add(0,0,0,0, 0,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0); // WAIT_BCP holds
      add(0,0,1,0, 0,2'd1,0 ,2'd1,3'b001,3'b000,      1,0,0);
      add(0,0,0,0, 1,2'd1,1 ,2'd1,3'b001,3'b001,      1,0,0); // (1,1)
      add(0,0,1,0, 0,2'd1,1 ,2'd1,3'b001,3'b001,      1,0,0);
      add(0,0,0,0, 0,2'd1,1 ,2'd0,3'b000,3'b000,      1,0,0); // pop to 0
      add(0,0,0,0, 0,2'd1,1 ,2'd0,3'b000,3'b000,      0,0,1); // UNSAT
      add(0,0,0,1, 0,2'd1,1 ,2'd0,3'b000,3'b000,      0,0,1); // 40 hold

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst3 = tbl[i].rst; start3 = tbl[i].start;
         conflict3 = tbl[i].conflict; bcp_done3 = tbl[i].bcp_done;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d", i),
             32'({dec_valid3, dec_var3, dec_value3, level3, mask3, vec3, busy3, sat3, unsat3}),
             32'(tbl[i].exp));
      end
      @(negedge clk);
      rst3 = 1'b0; start3 = 1'b0; conflict3 = 1'b0; bcp_done3 = 1'b0;

      // Single-variable instance: both polarities conflict -> UNSAT.
      @(negedge clk); rst1 = 1'b0; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      found = 0; cnt = 0;
      for (int k = 1; k <= 8 && !found; k++) begin
         @(posedge clk); #1;
         if (dec_valid1) begin found = 1; cnt = k; end
      end
      chk("v1_latency", 32'(cnt), 32'd1);
      chk("v1_dec0", 32'({dec_var1, dec_value1}), 32'({1'b1, 1'b0}));
      @(negedge clk); conflict1 = 1'b1;
      @(negedge clk); conflict1 = 1'b0;
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(posedge clk); #1;
         if (dec_valid1) found = 1;
      end
      chk("v1_flip_seen", 32'(found), 32'd1);
      chk("v1_dec1", 32'({dec_var1, dec_value1, vec1}), 32'({1'b1, 1'b1, 1'b1}));
      @(negedge clk); conflict1 = 1'b1;
      @(negedge clk); conflict1 = 1'b0;
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(posedge clk); #1;
         if (dp_unsat1_seen()) found = 1;
      end
      chk("v1_unsat_seen", 32'(found), 32'd1);
      chk("v1_final", 32'({level1, mask1, vec1, busy1, sat1, unsat1}), 32'(6'b000001));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic bit dp_unsat1_seen();
      return unsat1;
   endfunction

endmodule

// File: doc/dpll_decision_engine.md
DPLL_DECISION_ENGINE -- requirements
Module: dpll_decision_engine

Interface
REQ-001 The block SHALL expose parameter NUM_VARS, default 20, meaning the number of SAT variables (legal range 1..1023).
REQ-002 The block SHALL expose parameter VW, default $clog2(NUM_VARS+1), meaning the width of variable-index and level fields.
REQ-003 Port clk, input, 1, clock; all logic on the rising edge.
REQ-004 Port rst, input, 1, reset: synchronous, active-high; clock clk.
REQ-005 Port start, input, 1, one-cycle pulse that begins a solve; ignored unless the state is IDLE, SAT or UNSAT.
REQ-006 Port conflict, input, 1, BCP reports that the current assignment conflicts.
REQ-007 Port bcp_done, input, 1, BCP finished without conflict.
REQ-008 Port dec_valid, output, 1, one-cycle pulse marking a new or flipped decision.
REQ-009 Port dec_var, output, VW, 1-based index of the decided variable; valid with dec_valid.
REQ-010 Port dec_value, output, 1, polarity of the decision; valid with dec_valid.
REQ-011 Port level, output, VW, current decision level, equal to the count of assigned variables.
REQ-012 Port assign_mask, output, NUM_VARS, bit i-1 set means variable i is assigned.
REQ-013 Port value_vec, output, NUM_VARS, assigned values; bits of unassigned variables read 0.
REQ-014 Port busy, output, 1, high in DECIDE, WAIT_BCP and BACKTRACK.
REQ-015 Ports dp_sat and dp_unsat, outputs, 1 each, high and held while the state is SAT or UNSAT respectively.

Function
REQ-016 The FSM SHALL have the states IDLE, DECIDE, WAIT_BCP, BACKTRACK, SAT and UNSAT; each per-level flipped bit is held in an NUM_VARS-bit register.
REQ-017 On start from IDLE, SAT or UNSAT: clear level, assign_mask, value_vec and flipped, then enter DECIDE on the next cycle.
REQ-018 In DECIDE, in one cycle: level += 1; assign variable level+1 with the default polarity (0); clear its flipped bit; register dec_valid, dec_var and dec_value; go to WAIT_BCP.
REQ-019 dec_valid SHALL be high exactly in the first cycle of WAIT_BCP; start-pulse-to-dec_valid latency is 2 cycles.
REQ-020 In WAIT_BCP, including the dec_valid cycle: conflict goes to BACKTRACK; otherwise bcp_done goes to SAT if level==NUM_VARS, else to DECIDE; with neither asserted, the state holds.
REQ-021 When conflict and bcp_done are asserted simultaneously, conflict SHALL win.
REQ-022 In BACKTRACK with level==0, the next state SHALL be UNSAT.
REQ-023 In BACKTRACK with flipped[level]==0: invert the value of variable level, set flipped[level], pulse dec_valid with the new value, and go to WAIT_BCP (1 cycle).
REQ-024 In BACKTRACK with flipped[level]==1: unassign variable level, clear its value and flipped bit, level -= 1, and stay in BACKTRACK; this pops one level per cycle.
REQ-025 conflict and bcp_done SHALL be ignored outside WAIT_BCP.
REQ-026 SAT and UNSAT SHALL hold all outputs until start or rst.

Reset
REQ-027 rst SHALL force IDLE, level=0, assign_mask=0, value_vec=0, flipped=0, dec_valid=0, dec_var=0, dec_value=0, busy=0, dp_sat=0 and dp_unsat=0.
REQ-028 rst SHALL take priority over start, conflict and bcp_done, including mid-solve, and no dec_valid pulse SHALL follow it.

Configuration
REQ-029 Macro DPLL_DECISION_ENGINE_PHASE_SAVE_EN SHALL control phase saving.
- Defined: a NUM_VARS-bit saved-phase register records the last value of each variable at unassignment, and DECIDE uses the saved phase as polarity; the register is cleared by rst and start.
- Undefined: DECIDE always uses polarity 0 and the register is absent.

Verification
REQ-030 NUM_VARS=3, start, bcp_done after every dec_valid -> decisions (1,0),(2,0),(3,0); dp_sat=1, assign_mask=111, value_vec=000.
REQ-031 NUM_VARS=1, conflict after both decisions -> dec_valid (1,0) then (1,1); dp_unsat=1, level=0, assign_mask=0.
REQ-032 NUM_VARS=3, all bcp_done except conflict after both the (3,0) and (3,1) decisions -> level drops 3->2, then flip (2,1), then decide (3,0); all bcp_done thereafter -> dp_sat, value_vec=010 (var3..var1).
REQ-033 Conflict and bcp_done together at level 2 -> BACKTRACK taken, dec_valid (2,1).
REQ-034 rst asserted in WAIT_BCP at level 2 -> next cycle all outputs equal the REQ-027 values; a subsequent start restarts with (1,0).
REQ-035 With PHASE_SAVE_EN defined and the REQ-032 stimulus -> var3 is re-decided with polarity 1, producing dec_valid (3,1) after the pop.
